eq_stream_checker: RTL and testbench
====================================

# eq_stream_checker

Parametrised successor to the single-bit equality comparator. Compares two WIDTH-bit operand streams sample by sample, using one of four run-time comparison modes. Accumulates per-run statistics: samples seen, matches, sticky fail flag, index of the first failing sample. Sits between a stimulus source and the status/LED readout logic, and serves as a self-checking comparator for loopback and BIST paths.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- CNT_W, 16, width of length, counters and index (≥2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  one-cycle pulse; begins a run (honoured only in IDLE)
- len  in  CNT_W  samples in the run, sampled on start
- mode  in  2  00 a==b, 01 a!=b, 10 a<b unsigned, 11 a>b unsigned; sampled on start
- in_valid  in  1  a/b carry a sample this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cmp_out  out  1  registered comparison result of last accepted sample
- out_valid  out  1  cmp_out valid this cycle (one-cycle pulse per sample)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at end of run
- fail  out  1  sticky: some sample in current/last run compared false
- sample_cnt  out  CNT_W  samples accepted this run
- match_cnt  out  CNT_W  samples with comparison true this run
- first_fail_idx  out  CNT_W  0-based index of first false sample; 0 if none

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_valid ignored, no out_valid.
  - start latches len and mode, clears sample_cnt, match_cnt, fail and first_fail_idx.
  - Next state is RUN if len≠0, else DONE.
- RUN:
  - Each cycle with in_valid=1 accepts a sample.
  - cmp is evaluated using the latched mode, not the live mode input.
  - sample_cnt increments by 1.
  - match_cnt increments when cmp=1.
  - If cmp=0 and fail=0, first_fail_idx takes the pre-increment sample_cnt and fail sets.
  - The sample accepted with sample_cnt==len−1 moves the FSM to DONE.
  - start is ignored in RUN and DONE.
- DONE: lasts exactly one cycle with done=1, then IDLE. in_valid is ignored.
- Statistics hold their values after DONE until the next accepted start.
- Counters cannot overflow: sample_cnt ≤ len ≤ 2^CNT_W−1, and match_cnt ≤ sample_cnt.
- Comparisons are unsigned, full WIDTH, with no truncation.
- reset in any state, including mid-run, forces IDLE immediately at that edge. The partial run is discarded.
- Reset value of every output is 0: cmp_out, out_valid, busy, done, fail, sample_cnt, match_cnt, first_fail_idx.

## Timing
- Latency is 1 cycle. A sample accepted at edge N drives cmp_out/out_valid and the updated counters and flags after edge N+1's setup, i.e. in cycle N+1.
- Throughput is one sample per cycle. in_valid may be held high continuously, with no backpressure.
- done is asserted in the same cycle as out_valid for the last sample.
- len=0: done pulses the cycle after start, with all counters 0 and no out_valid.
- Minimum run spacing: start is accepted again in the cycle after done, back to back.
- busy rises the cycle after start and falls the cycle after done.
- start and reset in the same cycle: reset wins.

## Test plan
- Reset, then idle:
  - All outputs 0.
  - in_valid=1 with a=b=0x55 in IDLE gives no out_valid and sample_cnt stays 0.
- mode=00, len=4, pairs (3,3), (7,7), (1,2), (9,9) on consecutive cycles:
  - out_valid 4 cycles with cmp_out 1,1,0,1.
  - Final sample_cnt=4, match_cnt=3, fail=1, first_fail_idx=2.
  - done coincides with the 4th out_valid.
- Modes with WIDTH=8, len=3, pairs (0x00,0xFF), (0xFF,0x00), (0x80,0x80):
  - mode=10 gives cmp_out 1,0,0, match_cnt=1, first_fail_idx=1.
  - mode=11 gives 0,1,0, first_fail_idx=0.
  - mode=01 gives 1,1,0.
- Gapped input, len=3: in_valid pattern 1,0,0,1,0,1.
  - out_valid exactly 3 times.
  - done in the cycle after the 6th input cycle.
  - Changing mode mid-run has no effect.
- len=0: done pulses one cycle after start, counters 0, busy high one cycle. Back-to-back start is accepted the next cycle.
- Reset mid-run after 2 of 5 samples:
  - All outputs 0 next cycle and state IDLE.
  - A new start with len=1 completes normally with sample_cnt=1.

Source files
------------

// File: rtl/eq_stream_checker.sv
// eq_stream_checker: compares two WIDTH-bit operand streams sample by sample
// under one of four run-time modes and accumulates per-run statistics
// (samples seen, matches, sticky fail flag, index of first failing sample).
module eq_stream_checker #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             cmp_out,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] first_fail_idx
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [1:0]       mode_q, mode_d;
   logic             cmp_q, cmp_d;
   logic             ovalid_q, ovalid_d;
   logic             fail_q, fail_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;
   logic [CNT_W-1:0] ffi_q, ffi_d;
   logic             cmp_now;

   // Unsigned full-width comparison of the live operands under the latched mode.
   always_comb begin
      cmp_now = 1'b0;
      case (mode_q)
         2'b00:   cmp_now = (a == b);
         2'b01:   cmp_now = (a != b);
         2'b10:   cmp_now = (a < b);
         default: cmp_now = (a > b);
      endcase
   end

   // Run control: start latching, sample acceptance, statistics update.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      mode_d   = mode_q;
      cmp_d    = cmp_q;
      ovalid_d = 1'b0;
      fail_d   = fail_q;
      scnt_d   = scnt_q;
      mcnt_d   = mcnt_q;
      ffi_d    = ffi_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = len;
               mode_d  = mode;
               scnt_d  = '0;
               mcnt_d  = '0;
               fail_d  = 1'b0;
               ffi_d   = '0;
               state_d = (len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (in_valid) begin
               ovalid_d = 1'b1;
               cmp_d    = cmp_now;
               scnt_d   = scnt_q + CNT_ONE;
               if (cmp_now) begin
                  mcnt_d = mcnt_q + CNT_ONE;
               end else if (!fail_q) begin
                  fail_d = 1'b1;
                  ffi_d  = scnt_q;
               end
               if (scnt_q == len_q - CNT_ONE) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and statistics registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         mode_q   <= '0;
         cmp_q    <= 1'b0;
         ovalid_q <= 1'b0;
         fail_q   <= 1'b0;
         scnt_q   <= '0;
         mcnt_q   <= '0;
         ffi_q    <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         mode_q   <= mode_d;
         cmp_q    <= cmp_d;
         ovalid_q <= ovalid_d;
         fail_q   <= fail_d;
         scnt_q   <= scnt_d;
         mcnt_q   <= mcnt_d;
         ffi_q    <= ffi_d;
      end
   end

   assign cmp_out        = cmp_q;
   assign out_valid      = ovalid_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign fail           = fail_q;
   assign sample_cnt     = scnt_q;
   assign match_cnt      = mcnt_q;
   assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_eq_stream_checker.sv
// Testbench for eq_stream_checker: directed vector table, hand-written
// multi-cycle sequences and randomized runs against a behavioural model.
module tb_eq_stream_checker;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] len;
   logic [1:0]       mode;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cmp_out;
   logic             out_valid;
   logic             busy;
   logic             done;
   logic             fail;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] match_cnt;
   logic [CNT_W-1:0] first_fail_idx;

   always #5 clk = ~clk;

   eq_stream_checker #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .len           (len),
      .mode          (mode),
      .in_valid      (in_valid),
      .a             (a),
      .b             (b),
      .cmp_out       (cmp_out),
      .out_valid     (out_valid),
      .busy          (busy),
      .done          (done),
      .fail          (fail),
      .sample_cnt    (sample_cnt),
      .match_cnt     (match_cnt),
      .first_fail_idx(first_fail_idx)
   );

   int checks = 0;
   int errors = 0;

   // Per-run stimulus and expected results.
   logic [7:0]  sa [64];
   logic [7:0]  sb [64];
   bit          ecmp [64];
   int unsigned ematch;
   int unsigned effi;
   bit          efail;

   typedef struct {
      string       name;
      logic [1:0]  m;
      int unsigned n;
      logic [31:0] av;      // byte i = operand A of sample i
      logic [31:0] bv;
      logic [3:0]  exp_cmp; // bit i = expected result of sample i
      int unsigned exp_match;
      bit          exp_fail;
      int unsigned exp_ffi;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit ref_cmp(input logic [1:0] m, input int unsigned x, input int unsigned y);
      case (m)
         2'd0:    return x == y;
         2'd1:    return x != y;
         2'd2:    return x < y;
         default: return x > y;
      endcase
   endfunction

   function automatic void model(input logic [1:0] m, input int unsigned n);
      ematch = 0;
      efail  = 1'b0;
      effi   = 0;
      for (int unsigned i = 0; i < n; i++) begin
         ecmp[i] = ref_cmp(m, sa[i], sb[i]);
         if (ecmp[i]) ematch++;
         else if (!efail) begin
            efail = 1'b1;
            effi  = i;
         end
      end
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, " cmp_out"}, 32'(cmp_out), 0);
      chk({tag, " out_valid"}, 32'(out_valid), 0);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " done"}, 32'(done), 0);
      chk({tag, " fail"}, 32'(fail), 0);
      chk({tag, " sample_cnt"}, 32'(sample_cnt), 0);
      chk({tag, " match_cnt"}, 32'(match_cnt), 0);
      chk({tag, " first_fail_idx"}, 32'(first_fail_idx), 0);
   endtask

   // Drives one complete run from sa/sb and checks against ecmp/ematch/efail/effi.
   task automatic run_check(input logic [1:0] m, input int unsigned n, input int unsigned gap_pct,
                            input bit flip, input string tag);
      int unsigned i;
      int unsigned cyc;
      start    = 1'b1;
      len      = CNT_W'(n);
      mode     = m;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      chk({tag, " busy_after_start"}, 32'(busy), 1);
      i   = 0;
      cyc = 0;
      while (i < n && cyc < 2000) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         a = sa[i];
         b = sb[i];
         if (flip) mode = 2'($urandom);
         tick();
         cyc++;
         if (in_valid) begin
            chk({tag, " out_valid"}, 32'(out_valid), 1);
            chk({tag, " cmp_out"}, 32'(cmp_out), 32'(ecmp[i]));
            chk({tag, " sample_cnt_run"}, 32'(sample_cnt), i + 1);
            chk({tag, " done_run"}, 32'(done), 32'(i == n - 1));
            i++;
         end else begin
            chk({tag, " out_valid_gap"}, 32'(out_valid), 0);
            chk({tag, " done_gap"}, 32'(done), 0);
         end
      end
      if (i < n) chk({tag, " timeout"}, i, n);
      in_valid = 1'b0;
      chk({tag, " done_end"}, 32'(done), 1);
      chk({tag, " busy_end"}, 32'(busy), 1);
      chk({tag, " sample_cnt"}, 32'(sample_cnt), n);
      chk({tag, " match_cnt"}, 32'(match_cnt), ematch);
      chk({tag, " fail"}, 32'(fail), 32'(efail));
      chk({tag, " first_fail_idx"}, 32'(first_fail_idx), effi);
      // start and in_valid during the DONE cycle must be ignored
      start    = 1'b1;
      len      = 16'd7;
      in_valid = 1'b1;
      a        = 8'h00;
      b        = 8'h00;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk({tag, " busy_post"}, 32'(busy), 0);
      chk({tag, " done_post"}, 32'(done), 0);
      chk({tag, " out_valid_post"}, 32'(out_valid), 0);
      chk({tag, " sample_cnt_hold"}, 32'(sample_cnt), n);
      chk({tag, " match_cnt_hold"}, 32'(match_cnt), ematch);
      chk({tag, " fail_hold"}, 32'(fail), 32'(efail));
      chk({tag, " ffi_hold"}, 32'(first_fail_idx), effi);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] pat;
      logic [2:0] gexp;
      int unsigned ov;
      int unsigned k;

      vecs[0] = '{"eq4",    2'b00, 4, {8'd9, 8'd1, 8'd7, 8'd3}, {8'd9, 8'd2, 8'd7, 8'd3}, 4'b1011, 3, 1'b1, 2};
      vecs[1] = '{"lt3",    2'b10, 3, {8'h00, 8'h80, 8'hFF, 8'h00}, {8'h00, 8'h80, 8'h00, 8'hFF}, 4'b0001, 1, 1'b1, 1};
      vecs[2] = '{"gt3",    2'b11, 3, {8'h00, 8'h80, 8'hFF, 8'h00}, {8'h00, 8'h80, 8'h00, 8'hFF}, 4'b0010, 1, 1'b1, 0};
      vecs[3] = '{"ne3",    2'b01, 3, {8'h00, 8'h80, 8'hFF, 8'h00}, {8'h00, 8'h80, 8'h00, 8'hFF}, 4'b0011, 2, 1'b1, 2};
      vecs[4] = '{"eq1",    2'b00, 1, {24'h0, 8'd5}, {24'h0, 8'd5}, 4'b0001, 1, 1'b0, 0};
      vecs[5] = '{"gt_edge", 2'b11, 2, {16'h0, 8'h00, 8'hFF}, {16'h0, 8'h00, 8'hFE}, 4'b0001, 1, 1'b1, 1};
      vecs[6] = '{"lt_edge", 2'b10, 2, {16'h0, 8'h00, 8'hFE}, {16'h0, 8'h00, 8'hFF}, 4'b0001, 1, 1'b1, 1};

      reset    = 1'b1;
      start    = 1'b0;
      len      = '0;
      mode     = 2'b00;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      tick();
      tick();
      chk_all_zero("reset");

      // Idle: samples ignored
      reset    = 1'b0;
      in_valid = 1'b1;
      a        = 8'h55;
      b        = 8'h55;
      tick();
      tick();
      chk("idle out_valid", 32'(out_valid), 0);
      chk("idle sample_cnt", 32'(sample_cnt), 0);
      chk("idle busy", 32'(busy), 0);
      in_valid = 1'b0;

      // Reset and start together: reset wins
      reset = 1'b1;
      start = 1'b1;
      len   = 16'd3;
      tick();
      reset = 1'b0;
      start = 1'b0;
      chk("rst_start busy", 32'(busy), 0);
      tick();
      chk("rst_start busy2", 32'(busy), 0);

      // Directed vector table
      foreach (vecs[v]) begin
         for (int unsigned i = 0; i < vecs[v].n; i++) begin
            sa[i]   = vecs[v].av[8*i +: 8];
            sb[i]   = vecs[v].bv[8*i +: 8];
            ecmp[i] = vecs[v].exp_cmp[i];
         end
         ematch = vecs[v].exp_match;
         efail  = vecs[v].exp_fail;
         effi   = vecs[v].exp_ffi;
         run_check(vecs[v].m, vecs[v].n, 0, 1'b0, vecs[v].name);
      end

      // Gapped input with mode changing mid-run
      sa[0] = 8'd1; sb[0] = 8'd1;
      sa[1] = 8'd2; sb[1] = 8'd3;
      sa[2] = 8'd4; sb[2] = 8'd4;
      gexp  = 3'b101;
      pat   = 6'b101001;  // bit c = in_valid in cycle c
      start = 1'b1;
      len   = 16'd3;
      mode  = 2'b00;
      tick();
      start = 1'b0;
      ov    = 0;
      k     = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = pat[c];
         a        = sa[k];
         b        = sb[k];
         mode     = 2'(c + 1);
         tick();
         if (out_valid) ov++;
         chk("gap out_valid", 32'(out_valid), 32'(pat[c]));
         if (pat[c]) begin
            chk("gap cmp_out", 32'(cmp_out), 32'(gexp[k]));
            k++;
         end
         chk("gap done", 32'(done), 32'(c == 5));
      end
      in_valid = 1'b0;
      chk("gap out_valid_count", ov, 3);
      chk("gap match_cnt", 32'(match_cnt), 2);
      chk("gap fail", 32'(fail), 1);
      chk("gap first_fail_idx", 32'(first_fail_idx), 1);
      tick();
      chk("gap busy_after", 32'(busy), 0);

      // len=0 back to back, then a normal run right after
      model(2'b00, 0);
      run_check(2'b00, 0, 0, 1'b0, "len0_a");
      run_check(2'b01, 0, 0, 1'b0, "len0_b");
      sa[0] = 8'h12; sb[0] = 8'h34;
      model(2'b10, 1);
      run_check(2'b10, 1, 0, 1'b0, "after_len0");

      // Reset mid-run after 2 of 5 samples
      start = 1'b1;
      len   = 16'd5;
      mode  = 2'b00;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      a        = 8'h01;
      b        = 8'h02;
      tick();
      tick();
      chk("midrun sample_cnt", 32'(sample_cnt), 2);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk_all_zero("midrun_reset");
      sa[0] = 8'hAA; sb[0] = 8'hAA;
      model(2'b00, 1);
      run_check(2'b00, 1, 0, 1'b0, "after_reset");

      // Randomized runs against the reference model
      for (int r = 0; r < 40; r++) begin
         int unsigned n;
         logic [1:0]  m;
         n = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 12);
         m = 2'($urandom);
         for (int unsigned i = 0; i < n; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = ($urandom_range(3) == 0) ? sa[i] : 8'($urandom);
         end
         model(m, n);
         run_check(m, n, $urandom_range(0, 60), 1'b1, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
